shift_arbiter: RTL and testbench

Round-robin arbiter that shares one `barrel_shifter` instance (DATA_LEN-bit, combinational) between two independent requesters. Each requester presents a shift operation on a valid/ready port. The arbiter grants one request per cycle, drives the shared shifter with the granted operands and captures the result in a single-entry output register. The result is returned on a valid/ready response port tagged with the requester id. The block sits between the execution-side clients and the shifter datapath, replacing direct instantiation of the shifter by each client.

---
 rtl/shift_arbiter.sv | 133 +++++++++++++
 tb/tb_shift_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one barrel shifter between two requesters
// Holds the result in a single-entry register and returns it tagged with the requester id.

module barrel_shifter #(
  parameter int DATA_LEN  = 8,
  parameter int SHAMT_LEN = 3
) (
  input  logic [DATA_LEN-1:0]  din,
  input  logic [SHAMT_LEN-1:0] shamt,
  input  logic                 left,
  input  logic                 arith,
  output logic [DATA_LEN-1:0]  dout
);

  logic                              fill;
  logic [DATA_LEN-1:0]               rin;
  logic [SHAMT_LEN:0][DATA_LEN-1:0]  stg;

  // Left shifts reuse the right-shift stages on a bit-reversed operand.
  always_comb begin
    fill = arith & ~left & din[DATA_LEN-1];
    for (int i = 0; i < DATA_LEN; i++) begin
      rin[i] = left ? din[DATA_LEN-1-i] : din[i];
    end
  end

  assign stg[0] = rin;

  for (genvar s = 0; s < SHAMT_LEN; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stg[s+1] = shamt[s] ? {{SH{fill}}, stg[s][DATA_LEN-1:SH]} : stg[s];
  end

  always_comb begin
    for (int i = 0; i < DATA_LEN; i++) begin
      dout[i] = left ? stg[SHAMT_LEN][DATA_LEN-1-i] : stg[SHAMT_LEN][i];
    end
  end

endmodule

module shift_arbiter #(
  parameter int DATA_LEN  = 8,
  parameter int SHAMT_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*DATA_LEN-1:0]  req_din,
  input  logic [2*SHAMT_LEN-1:0] req_shamt,
  input  logic [1:0]             req_left,
  input  logic [1:0]             req_arith,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_LEN-1:0]    rsp_data,
  output logic                   rsp_id
);

  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_LEN-1:0]  rsp_data_q, rsp_data_d;
  logic                 rsp_id_q, rsp_id_d;
  logic                 prio_q, prio_d;

  logic                 can_accept;
  logic                 gnt_any;
  logic                 gnt_id;
  logic                 accept;
  logic [DATA_LEN-1:0]  sh_din;
  logic [SHAMT_LEN-1:0] sh_shamt;
  logic                 sh_left;
  logic                 sh_arith;
  logic [DATA_LEN-1:0]  sh_dout;

  always_comb begin
    can_accept = ~rsp_valid_q | rsp_ready;
    gnt_any    = |req_valid;
    gnt_id     = (&req_valid) ? prio_q : req_valid[1];
    // rst_n gates the grant so nothing is offered while reset is held.
    accept     = rst_n & can_accept & gnt_any;
    req_ready  = accept ? {gnt_id, ~gnt_id} : 2'b00;

    sh_din   = gnt_id ? req_din[2*DATA_LEN-1:DATA_LEN]     : req_din[DATA_LEN-1:0];
    sh_shamt = gnt_id ? req_shamt[2*SHAMT_LEN-1:SHAMT_LEN] : req_shamt[SHAMT_LEN-1:0];
    sh_left  = req_left[gnt_id];
    sh_arith = req_arith[gnt_id];
  end

  barrel_shifter #(
    .DATA_LEN  (DATA_LEN),
    .SHAMT_LEN (SHAMT_LEN)
  ) u_shifter (
    .din   (sh_din),
    .shamt (sh_shamt),
    .left  (sh_left),
    .arith (sh_arith),
    .dout  (sh_dout)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    prio_d      = prio_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sh_dout;
      rsp_id_d    = gnt_id;
      prio_d      = ~gnt_id;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      prio_q      <= prio_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - randomized self-checking bench for shift_arbiter
// A behavioural model predicts req_ready and the response register every cycle.

module tb_shift_arbiter;

  localparam int DL = 8;
  localparam int SL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*DL-1:0] req_din = '0;
  logic [2*SL-1:0] req_shamt = '0;
  logic [1:0]    req_left = 2'b00;
  logic [1:0]    req_arith = 2'b00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DL-1:0] rsp_data;
  logic          rsp_id;

  int checks = 0;
  int errors = 0;

  bit          m_valid = 1'b0;
  logic [7:0]  m_data  = 8'h00;
  bit          m_id    = 1'b0;
  bit          m_prio  = 1'b0;
  logic [1:0]  acc;

  shift_arbiter #(.DATA_LEN(DL), .SHAMT_LEN(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_shamt (req_shamt),
    .req_left  (req_left),
    .req_arith (req_arith),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] din, input int sh,
                                           input bit left, input bit arith);
    int v;
    v = din;
    if (left) return 8'((v << sh) % 256);
    if (arith && din[7]) return 8'((v >> sh) + (256 - (256 >> sh)));
    return 8'(v >> sh);
  endfunction

  function automatic logic [1:0] exp_ready();
    if (!rst_n) return 2'b00;
    if (m_valid && !rsp_ready) return 2'b00;
    if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_id    = 1'b0;
    m_prio  = 1'b0;
  end

  always @(posedge clk) begin
    logic [1:0] r;
    int g;
    if (rst_n) begin
      r = exp_ready();
      if (r != 2'b00) begin
        g = r[1] ? 1 : 0;
        m_data  = ref_shift(req_din[g*DL +: DL], int'(req_shamt[g*SL +: SL]),
                            req_left[g], req_arith[g]);
        m_id    = r[1];
        m_valid = 1'b1;
        m_prio  = ~r[1];
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(exp_ready()));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_data",  32'(rsp_data),  32'(m_data));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
  end

  task automatic tick();
    @(negedge clk);
    #1 acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] s,
                        input bit l, input bit a);
    req_din[i*DL +: DL]   = d;
    req_shamt[i*SL +: SL] = s;
    req_left[i]           = l;
    req_arith[i]          = a;
  endtask

  initial begin
    logic [7:0] hold;
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #2;
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_valid", 32'(rsp_valid), 32'h0);
    check("reset_data",  32'(rsp_data),  32'h0);
    check("reset_id",    32'(rsp_id),    32'h0);
    check("ref_arith",   32'(ref_shift(8'hB4, 2, 1'b0, 1'b1)), 32'hED);
    check("ref_left",    32'(ref_shift(8'hB4, 3, 1'b1, 1'b0)), 32'hA0);
    check("ref_logic",   32'(ref_shift(8'hB4, 2, 1'b0, 1'b0)), 32'h2D);
    check("ref_zero",    32'(ref_shift(8'hB4, 0, 1'b0, 1'b1)), 32'hB4);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    set_op(0, 8'hB4, 3'd2, 1'b0, 1'b1);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data",  32'(rsp_data),  32'hED);
    check("single_id",    32'(rsp_id),    32'h0);

    set_op(1, 8'hB4, 3'd3, 1'b1, 1'b0);
    req_valid = 2'b10;
    tick();
    check("left_data", 32'(rsp_data), 32'hA0);
    check("left_id",   32'(rsp_id),   32'h1);
    set_op(1, 8'hB4, 3'd2, 1'b0, 1'b0);
    tick();
    check("lsr_data", 32'(rsp_data), 32'h2D);
    set_op(1, 8'hB4, 3'd0, 1'b0, 1'b0);
    tick();
    check("pass_data", 32'(rsp_data), 32'hB4);
    req_valid = 2'b00;

    set_op(0, 8'h81, 3'd1, 1'b0, 1'b1);
    set_op(1, 8'h3C, 3'd2, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_valid", 32'(rsp_valid), 32'h1);
      check("rr_id",    32'(rsp_id),    32'(k % 2));
    end

    rsp_ready = 1'b0;
    hold = rsp_data;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_ready", 32'(req_ready), 32'h0);
      tick();
      check("stall_data",  32'(rsp_data),  32'(hold));
      check("stall_valid", 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    #1 check("fair_ready", 32'(req_ready), 32'h2);
    tick();
    check("fair_valid", 32'(rsp_valid), 32'h1);
    check("fair_id",    32'(rsp_id),    32'h1);

    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("postrst_id",   32'(rsp_id),   32'h0);
    check("postrst_data", 32'(rsp_data), 32'hC0);

    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          set_op(i, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1 check("rnd_rst_valid", 32'(rsp_valid), 32'h0);
        #2 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
